dtof_hist_sequencer: RTL

- Frame-level controller for the per-RAM histogram builder in the dToF pipeline.
- Sequences one frame as: clear, coarse pass (pass 0), peak search, clear, fine pass (pass 1), peak search, result readout.
- Gates TDC samples into the builder and stamps each accepted sample with pixel index and pass number.
- Holds the frame result behind a valid/ready handshake.

---
 rtl/dtof_hist_pkg.sv | 23 ++
 rtl/dtof_hist_sequencer_if.sv | 32 +++
 rtl/dtof_nested_counter.sv | 46 ++++
 rtl/dtof_hist_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/dtof_hist_pkg.sv
// Shared types, defaults and width helpers for the dToF histogram frame sequencer.
package dtof_hist_pkg;

  localparam int NP_DEF       = 12;
  localparam int NB_DEF       = 6;
  localparam int PIXELS_DEF   = 4;
  localparam int DATA_NUM_DEF = 4;
  localparam int ACQ_NUM_DEF  = 16;

  localparam logic PASS_COARSE = 1'b0;
  localparam logic PASS_FINE   = 1'b1;

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_ACQ, S_PEAK, S_RDOUT} seq_state_t;

  // Counter/address width for a bound; never narrower than one bit.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PIX_W_DEF = cw(PIXELS_DEF);
  localparam int CLR_W_DEF = cw(PIXELS_DEF << NB_DEF);

endpackage

// File: rtl/dtof_hist_sequencer_if.sv
// Sample input, builder write/clear, peak handshake and result handshake of the sequencer.
interface dtof_hist_sequencer_if #(
  parameter int NP = 12,
  parameter int PW = 2,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [NP-1:0] tdc_data;
  logic          hb_wr_en;
  logic [NP-1:0] hb_data;
  logic [PW-1:0] hb_pixel;
  logic          hb_pass;
  logic          hb_clr_en;
  logic [CW-1:0] hb_clr_addr;
  logic          peak_req;
  logic          peak_ack;
  logic          res_valid;
  logic          res_ready;

  modport master (
    input  in_valid, tdc_data, peak_ack, res_ready,
    output in_ready, hb_wr_en, hb_data, hb_pixel, hb_pass,
           hb_clr_en, hb_clr_addr, peak_req, res_valid
  );

  modport slave (
    output in_valid, tdc_data, peak_ack, res_ready,
    input  in_ready, hb_wr_en, hb_data, hb_pixel, hb_pass,
           hb_clr_en, hb_clr_addr, peak_req, res_valid
  );
endinterface

// File: rtl/dtof_nested_counter.sv
// Three-level sample/pixel/acquisition counter; each level wraps by compare and carries upward.
module dtof_nested_counter import dtof_hist_pkg::*; #(
  parameter  int N0 = 4,
  parameter  int N1 = 4,
  parameter  int N2 = 16,
  localparam int W0 = cw(N0),
  localparam int W1 = cw(N1),
  localparam int W2 = cw(N2)
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          en,
  output logic [W0-1:0] c0,
  output logic [W1-1:0] c1,
  output logic [W2-1:0] c2,
  output logic          last
);

  logic max0, max1, max2;
  assign max0 = (c0 == W0'(N0 - 1));
  assign max1 = (c1 == W1'(N1 - 1));
  assign max2 = (c2 == W2'(N2 - 1));
  assign last = max0 & max1 & max2;

  always_ff @(posedge clk) begin
    if (res || clr) begin
      c0 <= '0;
      c1 <= '0;
      c2 <= '0;
    end else if (en) begin
      if (max0) begin
        c0 <= '0;
        if (max1) begin
          c1 <= '0;
          c2 <= max2 ? '0 : c2 + 1'b1;
        end else begin
          c1 <= c1 + 1'b1;
        end
      end else begin
        c0 <= c0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dtof_hist_sequencer.sv
// Frame sequencer: clear, coarse pass, peak, clear, fine pass, peak, then result readout.
module dtof_hist_sequencer import dtof_hist_pkg::*; #(
  parameter  int NP         = NP_DEF,
  parameter  int NB         = NB_DEF,
  parameter  int PIXELS     = PIXELS_DEF,
  parameter  int DATA_NUM   = DATA_NUM_DEF,
  parameter  int ACQ_NUM    = ACQ_NUM_DEF,
  localparam int CLR_CYCLES = PIXELS << NB,
  localparam int PIX_W      = cw(PIXELS),
  localparam int CLR_W      = cw(CLR_CYCLES)
) (
  input  logic                   clk,
  input  logic                   res,
  input  logic                   start,
  dtof_hist_sequencer_if.master  bus,
  output logic                   busy,
  output logic                   frame_done
);

  seq_state_t state;
  logic       pass;
  logic       accept;
  logic       last;
  logic [cw(DATA_NUM)-1:0] c_smp;
  logic [PIX_W-1:0]        c_pix;
  logic [cw(ACQ_NUM)-1:0]  c_acq;

  assign accept = bus.in_valid & bus.in_ready;
  assign busy   = (state != S_IDLE);

  // Counters wrap to zero on the pass-ending accept, so the fine pass starts clean.
  dtof_nested_counter #(.N0(DATA_NUM), .N1(PIXELS), .N2(ACQ_NUM)) u_cnt (
    .clk  (clk),
    .res  (res),
    .clr  (state == S_IDLE),
    .en   (accept),
    .c0   (c_smp),
    .c1   (c_pix),
    .c2   (c_acq),
    .last (last)
  );

  always_ff @(posedge clk) begin
    if (res) begin
      state           <= S_IDLE;
      pass            <= PASS_COARSE;
      frame_done      <= 1'b0;
      bus.in_ready    <= 1'b0;
      bus.hb_wr_en    <= 1'b0;
      bus.hb_data     <= '0;
      bus.hb_pixel    <= '0;
      bus.hb_pass     <= 1'b0;
      bus.hb_clr_en   <= 1'b0;
      bus.hb_clr_addr <= '0;
      bus.peak_req    <= 1'b0;
      bus.res_valid   <= 1'b0;
    end else begin
      // Write path runs independently of the state so the last accept lands in PEAK.
      bus.hb_wr_en <= accept;
      frame_done   <= 1'b0;
      if (accept) begin
        bus.hb_data  <= bus.tdc_data;
        bus.hb_pixel <= c_pix;
        bus.hb_pass  <= pass;
      end
      case (state)
        S_IDLE: begin
          // frame_done is high only in the first IDLE cycle; a start there is dropped.
          if (start && !frame_done) begin
            state           <= S_CLR;
            pass            <= PASS_COARSE;
            bus.hb_clr_en   <= 1'b1;
            bus.hb_clr_addr <= '0;
          end
        end
        S_CLR: begin
          if (bus.hb_clr_addr == CLR_W'(CLR_CYCLES - 1)) begin
            state           <= S_ACQ;
            bus.hb_clr_en   <= 1'b0;
            bus.hb_clr_addr <= '0;
            bus.in_ready    <= 1'b1;
          end else begin
            bus.hb_clr_addr <= bus.hb_clr_addr + 1'b1;
          end
        end
        S_ACQ: begin
          if (accept && last) begin
            state        <= S_PEAK;
            bus.in_ready <= 1'b0;
            bus.peak_req <= 1'b1;
          end
        end
        S_PEAK: begin
          if (bus.peak_ack) begin
            bus.peak_req <= 1'b0;
            if (pass == PASS_COARSE) begin
              pass            <= PASS_FINE;
              state           <= S_CLR;
              bus.hb_clr_en   <= 1'b1;
              bus.hb_clr_addr <= '0;
            end else begin
              state         <= S_RDOUT;
              bus.res_valid <= 1'b1;
            end
          end
        end
        S_RDOUT: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            frame_done    <= 1'b1;
            pass          <= PASS_COARSE;
            state         <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
